// File: rtl/modmul_rr_sched_pkg.sv
// Shared constants and types for the round-robin modular-multiplier scheduler.
// Holds the modulus, Barrett constants, multiplier latency and FSM encoding.
package modmul_rr_sched_pkg;

  localparam int unsigned Q         = 3329;
  localparam int unsigned MUL_LAT   = 4;
  localparam int unsigned BARRETT_K = 24;
  localparam int unsigned BARRETT_M = 5039;  // floor(2^24 / 3329)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Lane-id width, kept at least one bit wide.
  function automatic int unsigned lane_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/modmul_rr_sched_grant.sv
// Combinational rotate-priority arbiter: grants the first valid lane at or
// after ptr, wrapping modulo NUM_REQ.
module rr_grant
  import modmul_rr_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = lane_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gid,
  output logic               found
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    idx   = '0;
    if (en) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        idx = ID_W'((32'(ptr) + off) % NUM_REQ);
        if (!found && valid[idx]) begin
          grant[idx] = 1'b1;
          gid        = idx;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/modmul_rr_sched_mul.sv
// Four-stage Barrett multiplier mod 3329: product, quotient estimate,
// remainder, single correction. Inputs must be < 3329; no valid tracking.
module modular_mul
  import modmul_rr_sched_pkg::*;
#(
  parameter int unsigned data_width = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  output logic [data_width-1:0] p
);

  localparam int unsigned DW = data_width;
  localparam int unsigned PW = 2 * data_width;
  localparam int unsigned QW = data_width + 1;
  localparam int unsigned MW = PW + 13;

  logic [PW-1:0] prod_q;
  logic [PW-1:0] prod2_q;
  logic [DW-1:0] qhat_q;
  logic [QW-1:0] r_q;

  // Estimate undershoots floor(x/q) by at most one, so r < 2q and one
  // conditional subtract finishes the reduction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      prod2_q <= '0;
      qhat_q  <= '0;
      r_q     <= '0;
      p       <= '0;
    end else begin
      prod_q  <= PW'(a) * PW'(b);
      prod2_q <= prod_q;
      qhat_q  <= DW'((MW'(prod_q) * MW'(BARRETT_M)) >> BARRETT_K);
      r_q     <= QW'(prod2_q - PW'(qhat_q) * PW'(Q));
      p       <= (r_q >= QW'(Q)) ? DW'(r_q - QW'(Q)) : DW'(r_q);
    end
  end

endmodule

// File: rtl/modmul_rr_sched.sv
// Round-robin scheduler sharing one pipelined mod-3329 multiplier among lanes.
// Optional MODMUL_RR_PERF_EN adds the perf_ops accepted-handshake counter.
module modmul_rr_sched
  import modmul_rr_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic                        busy
`ifdef MODMUL_RR_PERF_EN
  ,
  output logic [31:0]                 perf_ops
`endif
);

  localparam int unsigned ID_W = lane_id_w(NUM_REQ);

  state_e state_q, state_d;

  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   gid;
  logic              hs;
  logic              grant_en;
  logic              pending;
  logic [DATA_W-1:0] a_sel, b_sel;
  logic [TAG_W-1:0]  tag_sel;

  logic              op_valid_q;
  logic [ID_W-1:0]   op_id_q;
  logic [TAG_W-1:0]  op_tag_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [DATA_W-1:0] mul_p;

  logic [MUL_LAT-1:0] sv_valid;
  logic [ID_W-1:0]    sv_id  [MUL_LAT];
  logic [TAG_W-1:0]   sv_tag [MUL_LAT];

  assign grant_en = rst & ~hold & ~flush;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_grant (
    .valid (req_valid),
    .ptr   (ptr_q),
    .en    (grant_en),
    .grant (req_ready),
    .gid   (gid),
    .found (hs)
  );

  // Operand mux; grant is one-hot so an OR-reduction select suffices.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    tag_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        a_sel   = a_sel   | req_a[i*DATA_W +: DATA_W];
        b_sel   = b_sel   | req_b[i*DATA_W +: DATA_W];
        tag_sel = tag_sel | req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (hs) begin
      ptr_q <= (32'(gid) == NUM_REQ - 1) ? '0 : gid + ID_W'(1);
    end
  end

  // Issue stage feeding the multiplier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_valid_q <= 1'b0;
      op_id_q    <= '0;
      op_tag_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else begin
      op_valid_q <= hs & ~flush;
      if (hs) begin
        op_id_q  <= gid;
        op_tag_q <= tag_sel;
        op_a_q   <= a_sel;
        op_b_q   <= b_sel;
      end
    end
  end

  modular_mul #(
    .data_width (DATA_W)
  ) u_mul (
    .clk (clk),
    .rst (~rst),
    .a   (op_a_q),
    .b   (op_b_q),
    .p   (mul_p)
  );

  // Side pipe carrying {valid, id, tag} in lockstep with the multiplier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sv_valid <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        sv_id[i]  <= '0;
        sv_tag[i] <= '0;
      end
    end else begin
      sv_valid <= flush ? '0 : {sv_valid[MUL_LAT-2:0], op_valid_q};
      sv_id[0]  <= op_id_q;
      sv_tag[0] <= op_tag_q;
      for (int i = 1; i < MUL_LAT; i++) begin
        sv_id[i]  <= sv_id[i-1];
        sv_tag[i] <= sv_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else if (!flush && sv_valid[MUL_LAT-1]) begin
      rsp_valid <= NUM_REQ'(1) << sv_id[MUL_LAT-1];
      rsp_data  <= mul_p;
      rsp_tag   <= sv_tag[MUL_LAT-1];
    end else begin
      rsp_valid <= '0;
    end
  end

  // Ops that remain in flight after this edge (the last stage retires now).
  assign pending = op_valid_q | (|sv_valid[MUL_LAT-2:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (hs) state_d = RUN;
      RUN: begin
        if (!pending && !hs)    state_d = IDLE;
        else if (hold && pending) state_d = DRAIN;
      end
      DRAIN: begin
        if (hs)            state_d = RUN;
        else if (!pending) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  assign busy = (state_q != IDLE);

`ifdef MODMUL_RR_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      perf_ops <= '0;
    else if (flush) perf_ops <= '0;
    else if (hs)   perf_ops <= perf_ops + 32'd1;
  end
`endif

endmodule

// File: tb/tb_modmul_rr_sched.sv
// Directed self-checking bench for modmul_rr_sched (perf_ops checked when
// MODMUL_RR_PERF_EN is defined).
module tb_modmul_rr_sched;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 12;
  localparam int TAG_W   = 4;

  // Expected products for the round-robin lanes: 3328*2, 2*3, 1000*4, 3328*3328 mod 3329.
  localparam logic [11:0] RR_DATA [4] = '{12'd3327, 12'd6, 12'd671, 12'd1};

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      hold;
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [TAG_W-1:0]          rsp_tag;
  logic                      busy;
`ifdef MODMUL_RR_PERF_EN
  logic [31:0]               perf_ops;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  modmul_rr_sched #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
`ifdef MODMUL_RR_PERF_EN
    ,
    .perf_ops  (perf_ops)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic drive_lane(input int lane, input logic [11:0] a, input logic [11:0] b,
                            input logic [3:0] tag);
    req_a[lane*DATA_W +: DATA_W] = a;
    req_b[lane*DATA_W +: DATA_W] = b;
    req_tag[lane*TAG_W +: TAG_W] = tag;
  endtask

  task automatic test_reset;
    rst = 1'b0; hold = 1'b0; flush = 1'b0;
    req_valid = '1; req_a = '0; req_b = '0; req_tag = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    n_cmp++; if (rsp_data !== 12'd0) begin n_bad++; $display("FAIL reset_rsp_data got %0d want 0", rsp_data); end
    n_cmp++; if (rsp_tag !== 4'd0) begin n_bad++; $display("FAIL reset_rsp_tag got %0d want 0", rsp_tag); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef MODMUL_RR_PERF_EN
    n_cmp++; if (perf_ops !== 32'd0) begin n_bad++; $display("FAIL reset_perf got %0d want 0", perf_ops); end
`endif
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got %b want 0", busy); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_v;
    drive_lane(0, 12'd3328, 12'd2, 4'd8);
    drive_lane(1, 12'd2, 12'd3, 4'd9);
    drive_lane(2, 12'd1000, 12'd4, 4'd10);
    drive_lane(3, 12'd3328, 12'd3328, 4'd11);
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rr_grant0 got %b want 0001", req_ready); end
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      exp_v = (c >= 5 && c <= 12) ? 4'(1 << ((c - 5) % 4)) : 4'b0000;
      n_cmp++; if (rsp_valid !== exp_v) begin n_bad++; $display("FAIL rr_rsp_valid c=%0d got %b want %b", c, rsp_valid, exp_v); end
      if (c >= 5 && c <= 12) begin
        n_cmp++; if (rsp_data !== RR_DATA[(c - 5) % 4]) begin n_bad++; $display("FAIL rr_rsp_data c=%0d got %0d want %0d", c, rsp_data, RR_DATA[(c - 5) % 4]); end
        n_cmp++; if (rsp_tag !== 4'(8 + (c - 5) % 4)) begin n_bad++; $display("FAIL rr_rsp_tag c=%0d got %0d want %0d", c, rsp_tag, 8 + (c - 5) % 4); end
      end
      if (c == 11) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rr_busy_run got %b want 1", busy); end
      end
      if (c == 12) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_busy_idle got %b want 0", busy); end
      end
`ifdef MODMUL_RR_PERF_EN
      if (c == 13) begin
        n_cmp++; if (perf_ops !== 32'd8) begin n_bad++; $display("FAIL rr_perf got %0d want 8", perf_ops); end
      end
`endif
      if (c < 7) begin
        #1;
        n_cmp++; if (req_ready !== 4'(1 << ((c + 1) % 4))) begin n_bad++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, 4'(1 << ((c + 1) % 4))); end
      end
      if (c == 7) req_valid = '0;
    end
  endtask

  task automatic test_single;
    logic [3:0] exp_v;
    drive_lane(0, 12'd3328, 12'd3328, 4'd5);
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_grant got %b want 0001", req_ready); end
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = '0;
      exp_v = (c == 5) ? 4'b0001 : 4'b0000;
      n_cmp++; if (rsp_valid !== exp_v) begin n_bad++; $display("FAIL single_rsp_valid c=%0d got %b want %b", c, rsp_valid, exp_v); end
      if (c == 0) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", busy); end
      end
      if (c == 5) begin
        n_cmp++; if (rsp_data !== 12'd1) begin n_bad++; $display("FAIL single_rsp_data got %0d want 1", rsp_data); end
        n_cmp++; if (rsp_tag !== 4'd5) begin n_bad++; $display("FAIL single_rsp_tag got %0d want 5", rsp_tag); end
      end
      if (c == 6) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle got %b want 0", busy); end
      end
    end
  endtask

  task automatic test_two_lanes;
    logic [3:0] exp_v;
    drive_lane(1, 12'd0, 12'd3328, 4'd3);
    drive_lane(2, 12'd3000, 12'd3000, 4'd9);
    req_valid = 4'b0110;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL two_grant1 got %b want 0010", req_ready); end
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      exp_v = (c == 5) ? 4'b0010 : (c == 6) ? 4'b0100 : 4'b0000;
      n_cmp++; if (rsp_valid !== exp_v) begin n_bad++; $display("FAIL two_rsp_valid c=%0d got %b want %b", c, rsp_valid, exp_v); end
      if (c == 4) begin
        n_cmp++; if (rsp_data !== 12'd1) begin n_bad++; $display("FAIL two_data_hold got %0d want 1", rsp_data); end
      end
      if (c == 5) begin
        n_cmp++; if (rsp_data !== 12'd0) begin n_bad++; $display("FAIL two_lane1_data got %0d want 0", rsp_data); end
        n_cmp++; if (rsp_tag !== 4'd3) begin n_bad++; $display("FAIL two_lane1_tag got %0d want 3", rsp_tag); end
      end
      if (c == 6) begin
        n_cmp++; if (rsp_data !== 12'd1713) begin n_bad++; $display("FAIL two_lane2_data got %0d want 1713", rsp_data); end
        n_cmp++; if (rsp_tag !== 4'd9) begin n_bad++; $display("FAIL two_lane2_tag got %0d want 9", rsp_tag); end
      end
      if (c == 0) begin
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL two_grant2 got %b want 0100", req_ready); end
      end
      if (c == 1) req_valid = '0;
    end
  endtask

  task automatic test_flush;
    logic [3:0] exp_v;
    drive_lane(0, 12'd11, 12'd12, 4'd1);
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL flush_grant0 got %b want 0001", req_ready); end
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      exp_v = (c == 9) ? 4'b1000 : 4'b0000;
      n_cmp++; if (rsp_valid !== exp_v) begin n_bad++; $display("FAIL flush_rsp_valid c=%0d got %b want %b", c, rsp_valid, exp_v); end
      if (c == 9) begin
        n_cmp++; if (rsp_data !== 12'd35) begin n_bad++; $display("FAIL flush_after_data got %0d want 35", rsp_data); end
        n_cmp++; if (rsp_tag !== 4'd10) begin n_bad++; $display("FAIL flush_after_tag got %0d want 10", rsp_tag); end
      end
      case (c)
        0: begin
          drive_lane(1, 12'd13, 12'd14, 4'd2);
          req_valid = 4'b0010;
          #1;
          n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL flush_grant1 got %b want 0010", req_ready); end
        end
        1: begin
          drive_lane(2, 12'd15, 12'd16, 4'd3);
          req_valid = 4'b0100;
          #1;
          n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL flush_grant2 got %b want 0100", req_ready); end
        end
        2: begin
          n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before got %b want 1", busy); end
          drive_lane(3, 12'd5, 12'd7, 4'd10);
          flush = 1'b1;
          req_valid = 4'b1000;
          #1;
          n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_no_grant got %b want 0000", req_ready); end
        end
        3: begin
          n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_idle got %b want 0", busy); end
`ifdef MODMUL_RR_PERF_EN
          n_cmp++; if (perf_ops !== 32'd0) begin n_bad++; $display("FAIL flush_perf_clear got %0d want 0", perf_ops); end
`endif
          flush = 1'b0;
          #1;
          n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL flush_grant3 got %b want 1000", req_ready); end
        end
        4: begin
`ifdef MODMUL_RR_PERF_EN
          n_cmp++; if (perf_ops !== 32'd1) begin n_bad++; $display("FAIL flush_perf_one got %0d want 1", perf_ops); end
`endif
          req_valid = '0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_hold;
    logic [3:0] exp_v;
    logic       exp_busy;
    drive_lane(0, 12'd10, 12'd20, 4'd1);
    drive_lane(1, 12'd3328, 12'd3, 4'd2);
    drive_lane(2, 12'd2000, 12'd2000, 4'd3);
    req_valid = 4'b0011;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL hold_grant0 got %b want 0001", req_ready); end
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      exp_v = (c == 5) ? 4'b0001 : (c == 6) ? 4'b0010 : (c == 13) ? 4'b0100 : 4'b0000;
      exp_busy = (c <= 5) || (c >= 8 && c <= 12);
      n_cmp++; if (rsp_valid !== exp_v) begin n_bad++; $display("FAIL hold_rsp_valid c=%0d got %b want %b", c, rsp_valid, exp_v); end
      n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL hold_busy c=%0d got %b want %b", c, busy, exp_busy); end
      if (c == 5) begin
        n_cmp++; if (rsp_data !== 12'd200) begin n_bad++; $display("FAIL hold_data0 got %0d want 200", rsp_data); end
      end
      if (c == 6) begin
        n_cmp++; if (rsp_data !== 12'd3326) begin n_bad++; $display("FAIL hold_data1 got %0d want 3326", rsp_data); end
        n_cmp++; if (rsp_tag !== 4'd2) begin n_bad++; $display("FAIL hold_tag1 got %0d want 2", rsp_tag); end
      end
      if (c == 13) begin
        n_cmp++; if (rsp_data !== 12'd1871) begin n_bad++; $display("FAIL hold_data2 got %0d want 1871", rsp_data); end
        n_cmp++; if (rsp_tag !== 4'd3) begin n_bad++; $display("FAIL hold_tag2 got %0d want 3", rsp_tag); end
      end
      case (c)
        0: begin
          req_valid = 4'b0010;
          #1;
          n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL hold_grant1 got %b want 0010", req_ready); end
        end
        1: begin
          req_valid = 4'b0100;
          hold = 1'b1;
          #1;
          n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL hold_blocked got %b want 0000", req_ready); end
        end
        6: begin
          #1;
          n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL hold_still_blocked got %b want 0000", req_ready); end
        end
        7: begin
          hold = 1'b0;
          #1;
          n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL hold_release_grant got %b want 0100", req_ready); end
        end
        8: req_valid = '0;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid;
    for (int l = 0; l < NUM_REQ; l++) drive_lane(l, 12'd1, 12'd1, 4'(l));
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL rstmid_grant got %b want 1000", req_ready); end
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c == 3) begin
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rstmid_ready got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL rstmid_rsp_valid got %b want 0000", rsp_valid); end
        n_cmp++; if (rsp_data !== 12'd0) begin n_bad++; $display("FAIL rstmid_rsp_data got %0d want 0", rsp_data); end
        n_cmp++; if (rsp_tag !== 4'd0) begin n_bad++; $display("FAIL rstmid_rsp_tag got %0d want 0", rsp_tag); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
`ifdef MODMUL_RR_PERF_EN
        n_cmp++; if (perf_ops !== 32'd0) begin n_bad++; $display("FAIL rstmid_perf got %0d want 0", perf_ops); end
`endif
      end
      if (c == 4) begin
        req_valid = '0;
        rst = 1'b1;
      end
      if (c >= 4) begin
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL rstmid_stray c=%0d got %b want 0000", c, rsp_valid); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_two_lanes;
    test_flush;
    test_hold;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
